// File: rtl/fwd_pkg.sv
// Shared constants and helpers for the operand-forwarding stage.
// Select codes: SEL_RF picks the register file, SEL_FWD_BASE + j picks forwarding source j.
package fwd_pkg;

    localparam int REG_ZERO     = 0;
    localparam int SEL_RF       = 0;
    localparam int SEL_FWD_BASE = 1;

    // One code for the register file plus one per forwarding source.
    function automatic int sel_width(input int nsrc);
        return (nsrc < 1) ? 1 : $clog2(nsrc + 1);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Combinational priority selector for one source operand.
// The lowest-indexed (youngest) matching source wins; register 0 never forwards.
module fwd_select
    import fwd_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int REGW  = 5,
    parameter  int NSRC  = 2,
    localparam int SELW  = sel_width(NSRC)
) (
    input  logic [REGW-1:0]       src_reg,
    input  logic [WIDTH-1:0]      rf_val,
    input  logic [NSRC-1:0]       fwd_wen,
    input  logic [NSRC*REGW-1:0]  fwd_reg,
    input  logic [NSRC*WIDTH-1:0] fwd_data,
    output logic [WIDTH-1:0]      op,
    output logic [SELW-1:0]       sel
);

    logic src_nonzero;

    assign src_nonzero = (src_reg != REGW'(REG_ZERO));

    // Walk from the oldest source to the youngest so the youngest match is the last write.
    always_comb begin
        op  = rf_val;
        sel = SELW'(SEL_RF);
        for (int j = NSRC - 1; j >= 0; j--) begin
            if (src_nonzero && fwd_wen[j] && (fwd_reg[j*REGW +: REGW] == src_reg)) begin
                op  = fwd_data[j*WIDTH +: WIDTH];
                sel = SELW'(j + SEL_FWD_BASE);
            end
        end
    end

endmodule

// File: rtl/fwd_operand_stage.sv
// Operand forwarding, load-use hazard detection and the ID/EX operand register.
// A hazard bubble keeps ex_op/ex_fwd_sel/ex_dst_reg; consumers qualify them with ex_valid.
module fwd_operand_stage
    import fwd_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int REGW  = 5,
    parameter  int NSRC  = 2,
    parameter  int NOPS  = 2,
    parameter  int CNTW  = 16,
    localparam int SELW  = sel_width(NSRC)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [NOPS*REGW-1:0]   id_src_reg,
    input  logic [NOPS*WIDTH-1:0]  id_src_val,
    input  logic [REGW-1:0]        id_dst_reg,
    input  logic                   id_dst_wen,
    input  logic                   id_is_load,
    input  logic [NSRC-1:0]        fwd_wen,
    input  logic [NSRC*REGW-1:0]   fwd_reg,
    input  logic [NSRC*WIDTH-1:0]  fwd_data,
    input  logic                   stall_in,
    input  logic                   flush,
    output logic                   ex_valid,
    output logic [NOPS*WIDTH-1:0]  ex_op,
    output logic [REGW-1:0]        ex_dst_reg,
    output logic                   ex_dst_wen,
    output logic                   ex_is_load,
    output logic [NOPS*SELW-1:0]   ex_fwd_sel,
    output logic                   stall_out,
    output logic [CNTW-1:0]        stall_cnt
);

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    logic [NOPS*WIDTH-1:0] res_op;
    logic [NOPS*SELW-1:0]  res_sel;
    logic                  src_hit;
    logic                  hazard;

    for (genvar k = 0; k < NOPS; k++) begin : g_sel
        fwd_select #(
            .WIDTH (WIDTH),
            .REGW  (REGW),
            .NSRC  (NSRC)
        ) u_sel (
            .src_reg  (id_src_reg[k*REGW +: REGW]),
            .rf_val   (id_src_val[k*WIDTH +: WIDTH]),
            .fwd_wen  (fwd_wen),
            .fwd_reg  (fwd_reg),
            .fwd_data (fwd_data),
            .op       (res_op[k*WIDTH +: WIDTH]),
            .sel      (res_sel[k*SELW +: SELW])
        );
    end

    // Hazard uses only registered EX state and ID indices, never forwarded data.
    always_comb begin
        src_hit = 1'b0;
        for (int k = 0; k < NOPS; k++) begin
            if (id_src_reg[k*REGW +: REGW] == ex_dst_reg) begin
                src_hit = 1'b1;
            end
        end
    end

    assign hazard    = id_valid & ex_valid & ex_is_load & ex_dst_wen
                     & (ex_dst_reg != REGW'(REG_ZERO)) & src_hit;
    assign stall_out = hazard & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            ex_op      <= '0;
            ex_dst_reg <= '0;
            ex_dst_wen <= 1'b0;
            ex_is_load <= 1'b0;
            ex_fwd_sel <= '0;
            stall_cnt  <= '0;
        end else if (flush) begin
            ex_valid   <= 1'b0;
            ex_op      <= '0;
            ex_dst_reg <= '0;
            ex_dst_wen <= 1'b0;
            ex_is_load <= 1'b0;
            ex_fwd_sel <= '0;
        end else if (stall_in) begin
            ex_valid   <= ex_valid;
        end else if (hazard) begin
            ex_valid   <= 1'b0;
            ex_dst_wen <= 1'b0;
            ex_is_load <= 1'b0;
            if (stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + CNTW'(1);
            end
        end else begin
            ex_valid   <= id_valid;
            ex_op      <= res_op;
            ex_dst_reg <= id_dst_reg;
            ex_dst_wen <= id_valid & id_dst_wen;
            ex_is_load <= id_valid & id_is_load;
            ex_fwd_sel <= res_sel;
        end
    end

endmodule

// File: tb/tb_fwd_operand_stage.sv
// Randomised and directed bench for fwd_operand_stage with a behavioural model.
// A second instance with CNTW=2 shares all inputs to exercise counter saturation.
module tb_fwd_operand_stage;

    localparam int W   = 32;
    localparam int R   = 5;
    localparam int NS  = 2;
    localparam int NO  = 2;
    localparam int SW  = 2;
    localparam int CW  = 16;
    localparam int CWS = 2;
    localparam int FW  = 1 + NO*W + R + 1 + 1 + NO*SW;
    localparam int VW  = 2*FW + CW + CWS;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              id_valid;
    logic [NO*R-1:0]   id_src_reg;
    logic [NO*W-1:0]   id_src_val;
    logic [R-1:0]      id_dst_reg;
    logic              id_dst_wen;
    logic              id_is_load;
    logic [NS-1:0]     fwd_wen;
    logic [NS*R-1:0]   fwd_reg;
    logic [NS*W-1:0]   fwd_data;
    logic              stall_in;
    logic              flush;

    logic              ex_valid, ex_dst_wen, ex_is_load, stall_out;
    logic [NO*W-1:0]   ex_op;
    logic [R-1:0]      ex_dst_reg;
    logic [NO*SW-1:0]  ex_fwd_sel;
    logic [CW-1:0]     stall_cnt;

    logic              s_ex_valid, s_ex_dst_wen, s_ex_is_load, s_stall_out;
    logic [NO*W-1:0]   s_ex_op;
    logic [R-1:0]      s_ex_dst_reg;
    logic [NO*SW-1:0]  s_ex_fwd_sel;
    logic [CWS-1:0]    s_stall_cnt;

    fwd_operand_stage #(.WIDTH(W), .REGW(R), .NSRC(NS), .NOPS(NO), .CNTW(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_reg(id_src_reg),
        .id_src_val(id_src_val), .id_dst_reg(id_dst_reg), .id_dst_wen(id_dst_wen),
        .id_is_load(id_is_load), .fwd_wen(fwd_wen), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
        .stall_in(stall_in), .flush(flush), .ex_valid(ex_valid), .ex_op(ex_op),
        .ex_dst_reg(ex_dst_reg), .ex_dst_wen(ex_dst_wen), .ex_is_load(ex_is_load),
        .ex_fwd_sel(ex_fwd_sel), .stall_out(stall_out), .stall_cnt(stall_cnt)
    );

    fwd_operand_stage #(.WIDTH(W), .REGW(R), .NSRC(NS), .NOPS(NO), .CNTW(CWS)) dut_s (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_reg(id_src_reg),
        .id_src_val(id_src_val), .id_dst_reg(id_dst_reg), .id_dst_wen(id_dst_wen),
        .id_is_load(id_is_load), .fwd_wen(fwd_wen), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
        .stall_in(stall_in), .flush(flush), .ex_valid(s_ex_valid), .ex_op(s_ex_op),
        .ex_dst_reg(s_ex_dst_reg), .ex_dst_wen(s_ex_dst_wen), .ex_is_load(s_ex_is_load),
        .ex_fwd_sel(s_ex_fwd_sel), .stall_out(s_stall_out), .stall_cnt(s_stall_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: what the EX register should hold, plus an unbounded hazard count.
    logic             m_valid, m_wen, m_load;
    logic [NO*W-1:0]  m_op;
    logic [R-1:0]     m_dst;
    logic [NO*SW-1:0] m_sel;
    int               m_cnt;

    function automatic void m_reset();
        m_valid = 1'b0; m_wen = 1'b0; m_load = 1'b0;
        m_op = '0; m_dst = '0; m_sel = '0; m_cnt = 0;
    endfunction

    function automatic logic m_hazard();
        if (!(id_valid && m_valid && m_load && m_wen) || m_dst == 0) return 1'b0;
        for (int k = 0; k < NO; k++)
            if (id_src_reg[k*R +: R] == m_dst) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_resolve(output logic [NO*W-1:0] op, output logic [NO*SW-1:0] sel);
        logic [R-1:0] s;
        op = '0; sel = '0;
        for (int k = 0; k < NO; k++) begin
            s = id_src_reg[k*R +: R];
            op[k*W +: W]   = id_src_val[k*W +: W];
            sel[k*SW +: SW] = '0;
            for (int j = 0; j < NS; j++) begin
                if (s != 0 && fwd_wen[j] && fwd_reg[j*R +: R] == s) begin
                    op[k*W +: W]    = fwd_data[j*W +: W];
                    sel[k*SW +: SW] = SW'(j + 1);
                    break;
                end
            end
        end
    endfunction

    function automatic void m_step();
        logic hz;
        logic [NO*W-1:0] op;
        logic [NO*SW-1:0] sel;
        hz = m_hazard();
        m_resolve(op, sel);
        if (flush) begin
            m_valid = 1'b0; m_wen = 1'b0; m_load = 1'b0;
            m_op = '0; m_dst = '0; m_sel = '0;
        end else if (stall_in) begin
            m_valid = m_valid;
        end else if (hz) begin
            m_valid = 1'b0; m_wen = 1'b0; m_load = 1'b0;
            m_cnt++;
        end else begin
            m_valid = id_valid; m_op = op; m_sel = sel; m_dst = id_dst_reg;
            m_wen = id_valid & id_dst_wen; m_load = id_valid & id_is_load;
        end
    endfunction

    function automatic logic [FW-1:0] m_fields();
        return {m_valid, m_op, m_dst, m_wen, m_load, m_sel};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        int c16, c2;
        c16 = (m_cnt > 65535) ? 65535 : m_cnt;
        c2  = (m_cnt > 3) ? 3 : m_cnt;
        return {m_fields(), m_fields(), CW'(c16), CWS'(c2)};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {ex_valid, ex_op, ex_dst_reg, ex_dst_wen, ex_is_load, ex_fwd_sel,
                s_ex_valid, s_ex_op, s_ex_dst_reg, s_ex_dst_wen, s_ex_is_load, s_ex_fwd_sel,
                stall_cnt, s_stall_cnt};
    endfunction

    task automatic tick();
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 1'b0; id_src_reg = '0; id_src_val = '0; id_dst_reg = '0;
        id_dst_wen = 1'b0; id_is_load = 1'b0; fwd_wen = '0; fwd_reg = '0;
        fwd_data = '0; stall_in = 1'b0; flush = 1'b0;
    endtask

    task automatic rand_id(input int maxreg);
        id_valid   = 1'b1;
        id_dst_reg = R'($urandom_range(maxreg, 1));
        id_dst_wen = 1'b1;
        id_is_load = 1'b0;
        for (int k = 0; k < NO; k++) begin
            id_src_reg[k*R +: R] = R'($urandom_range(maxreg, 0));
            id_src_val[k*W +: W] = $urandom;
        end
        for (int j = 0; j < NS; j++) begin
            fwd_reg[j*R +: R]  = R'($urandom_range(maxreg, 0));
            fwd_data[j*W +: W] = $urandom;
        end
        fwd_wen = NS'($urandom);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        m_reset();
        #2;
        checks++;
        if (obs_vec() !== '0 || stall_out !== 1'b0 || s_stall_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got %h so=%b want 0", obs_vec(), stall_out);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_idle got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_priority();
        idle_inputs();
        id_valid = 1'b1;
        id_src_reg = {R'(7), R'(5)};
        id_src_val = {32'h1111_2222, 32'h3333_4444};
        fwd_wen = 2'b11;
        fwd_reg = {R'(5), R'(5)};
        fwd_data = {32'h5555_0000, 32'hAAAA_0000};
        tick();
        checks++;
        if (ex_op[W-1:0] !== 32'hAAAA_0000 || ex_fwd_sel[SW-1:0] !== 2'd1) begin
            errors++;
            $display("FAIL priority got op=%h sel=%0d want op=aaaa0000 sel=1",
                     ex_op[W-1:0], ex_fwd_sel[SW-1:0]);
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL priority_state got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_zero_reg();
        idle_inputs();
        id_valid = 1'b1;
        id_src_reg = {R'(0), R'(0)};
        fwd_wen = 2'b01;
        fwd_reg = {R'(0), R'(0)};
        fwd_data = {32'h0, 32'hDEAD_BEEF};
        tick();
        checks++;
        if (ex_op[W-1:0] !== 32'h0 || ex_fwd_sel[SW-1:0] !== 2'd0) begin
            errors++;
            $display("FAIL zero_reg got op=%h sel=%0d want op=0 sel=0",
                     ex_op[W-1:0], ex_fwd_sel[SW-1:0]);
        end
    endtask

    task automatic test_load_use();
        idle_inputs();
        id_valid = 1'b1; id_is_load = 1'b1; id_dst_reg = R'(3); id_dst_wen = 1'b1;
        id_src_reg = {R'(2), R'(1)};
        tick();
        idle_inputs();
        id_valid = 1'b1; id_dst_reg = R'(6); id_dst_wen = 1'b1;
        id_src_reg = {R'(0), R'(3)};
        id_src_val = {32'h0, 32'h0BAD_0BAD};
        #1;
        checks++;
        if (stall_out !== 1'b1 || s_stall_out !== 1'b1) begin
            errors++;
            $display("FAIL load_use_stall got %b want 1", stall_out);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b0 || stall_cnt !== 16'd1 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL load_use_bubble got v=%b cnt=%0d want v=0 cnt=1", ex_valid, stall_cnt);
        end
        fwd_wen = 2'b10;
        fwd_reg = {R'(3), R'(0)};
        fwd_data = {32'hC0DE_0003, 32'h0};
        #1;
        checks++;
        if (stall_out !== 1'b0) begin
            errors++;
            $display("FAIL load_use_one_cycle got %b want 0", stall_out);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_op[W-1:0] !== 32'hC0DE_0003 || ex_fwd_sel[SW-1:0] !== 2'd2) begin
            errors++;
            $display("FAIL load_use_retry got v=%b op=%h sel=%0d want v=1 op=c0de0003 sel=2",
                     ex_valid, ex_op[W-1:0], ex_fwd_sel[SW-1:0]);
        end
    endtask

    task automatic test_flush_hazard();
        idle_inputs();
        tick();
        id_valid = 1'b1; id_is_load = 1'b1; id_dst_reg = R'(9); id_dst_wen = 1'b1;
        tick();
        idle_inputs();
        id_valid = 1'b1; id_src_reg = {R'(9), R'(4)}; flush = 1'b1;
        #1;
        checks++;
        if (stall_out !== 1'b0 || s_stall_out !== 1'b0) begin
            errors++;
            $display("FAIL flush_hazard_stall got %b want 0", stall_out);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL flush_hazard_state got %h want %h", obs_vec(), exp_vec());
        end
        flush = 1'b0;
    endtask

    task automatic test_stall_hold();
        logic [FW-1:0] held;
        idle_inputs();
        rand_id(31);
        tick();
        held = m_fields();
        stall_in = 1'b1;
        for (int c = 0; c < 3; c++) begin
            rand_id(31);
            tick();
            checks++;
            if ({ex_valid, ex_op, ex_dst_reg, ex_dst_wen, ex_is_load, ex_fwd_sel} !== held
                || obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got %h want %h", c, obs_vec(), exp_vec());
            end
        end
        stall_in = 1'b0;
        rand_id(31);
        tick();
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL stall_release got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_saturation();
        idle_inputs();
        tick();
        id_valid = 1'b1; id_is_load = 1'b1; id_dst_reg = R'(4); id_dst_wen = 1'b1;
        id_src_reg = {R'(0), R'(4)};
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            checks++;
            if (stall_out !== 1'b1) begin
                errors++;
                $display("FAIL sat_hazard %0d got %b want 1", i, stall_out);
            end
            tick();
        end
        checks++;
        if (s_stall_cnt !== 2'd3 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL saturation got cnt2=%0d cnt16=%0d want cnt2=3 cnt16=%0d",
                     s_stall_cnt, stall_cnt, m_cnt);
        end
    endtask

    task automatic test_random();
        logic exp_so;
        for (int c = 0; c < 300; c++) begin
            rand_id(3);
            id_valid   = ($urandom_range(9, 0) < 8);
            id_is_load = ($urandom_range(9, 0) < 4);
            id_dst_wen = ($urandom_range(9, 0) < 8);
            flush      = ($urandom_range(9, 0) == 0);
            stall_in   = ($urandom_range(7, 0) == 0);
            #1;
            exp_so = m_hazard() & ~flush;
            checks++;
            if (stall_out !== exp_so || s_stall_out !== exp_so) begin
                errors++;
                $display("FAIL random_stall %0d got %b want %b", c, stall_out, exp_so);
            end
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_state %0d got %h want %h", c, obs_vec(), exp_vec());
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_stall();
        idle_inputs();
        tick();
        id_valid = 1'b1; id_is_load = 1'b1; id_dst_reg = R'(2); id_dst_wen = 1'b1;
        tick();
        idle_inputs();
        id_valid = 1'b1; id_src_reg = {R'(2), R'(0)};
        #1;
        checks++;
        if (stall_out !== 1'b1) begin
            errors++;
            $display("FAIL mid_stall_pre got %b want 1", stall_out);
        end
        #1;
        rst = 1'b1;
        m_reset();
        #1;
        checks++;
        if (obs_vec() !== '0 || stall_out !== 1'b0 || s_stall_out !== 1'b0) begin
            errors++;
            $display("FAIL mid_stall_reset got %h so=%b want 0", obs_vec(), stall_out);
        end
        #2;
        rst = 1'b0;
        idle_inputs();
        tick();
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL after_reset got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_zero_reg();
        test_load_use();
        test_flush_hazard();
        test_stall_hold();
        test_saturation();
        test_random();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
